// File: rtl/fft16_pkg.sv
// Shared types and helpers for the 16-point FFT output reorder stage.
package fft16_pkg;

  localparam int unsigned N_POINTS = 16;
  localparam int unsigned LOG2_N   = 4;

  typedef logic [31:0] flp32_t;

  typedef struct packed {
    flp32_t re;
    flp32_t im;
  } cplx_t;

  function automatic logic [LOG2_N-1:0] bitrev4(input logic [LOG2_N-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft16_frame_bank.sv
// One frame of 16 complex words: whole-frame write port, single addressed read port.
module fft16_frame_bank
  import fft16_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  cplx_t             wr_frame [N_POINTS],
  input  logic [LOG2_N-1:0] rd_addr,
  output cplx_t             rd_data
);

  // Storage is deliberately not reset; the bank-state flags gate its use.
  cplx_t mem_q [N_POINTS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q <= wr_frame;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fft16_output_reorder.sv
// Captures a bit-reversed parallel FFT frame and streams it out in natural order.
// Define FFT16_REORDER_PINGPONG_EN for a second bank (capture overlaps streaming).
module fft16_output_reorder #(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real [0:15],
  input  logic [DATA_W-1:0] in_img  [0:15],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_img,
  output logic [3:0]        out_index,
  output logic              out_last
);
  import fft16_pkg::*;

  if (N_POINTS != fft16_pkg::N_POINTS || DATA_W != $bits(flp32_t)) begin : g_cfg_check
    $error("fft16_output_reorder supports only N_POINTS=16 and DATA_W=32");
  end

  cplx_t             wr_frame [fft16_pkg::N_POINTS];
  cplx_t             rd_sample;
  logic [LOG2_N-1:0] k_q, k_d;
  logic [LOG2_N-1:0] rd_addr;
  logic              in_fire, out_fire, frame_done;

  always_comb begin
    for (int i = 0; i < int'(fft16_pkg::N_POINTS); i++) begin
      wr_frame[i].re = in_real[i];
      wr_frame[i].im = in_img[i];
    end
  end

  assign rd_addr    = bitrev4(k_q);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign frame_done = out_fire && (k_q == 4'd15);
  assign k_d        = out_fire ? k_q + 4'd1 : k_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

`ifdef FFT16_REORDER_PINGPONG_EN
  logic [1:0] full_q, full_d;
  logic       wr_ptr_q, rd_ptr_q;
  cplx_t      rd_bank [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft16_frame_bank u_bank (
      .clk      (clk),
      .we       (in_fire && (wr_ptr_q == 1'(b))),
      .wr_frame (wr_frame),
      .rd_addr  (rd_addr),
      .rd_data  (rd_bank[b])
    );
  end

  // Capture only targets a FREE bank, so it never collides with the bank being drained.
  always_comb begin
    full_d = full_q;
    if (frame_done) full_d[rd_ptr_q] = 1'b0;
    if (in_fire)    full_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_q ^ in_fire;
      rd_ptr_q <= rd_ptr_q ^ frame_done;
    end
  end

  // Frames are written and read in the same alternating order, so the next frame
  // to stream always sits in the other bank.
  assign in_ready  = ~&full_q;
  assign out_valid = full_q[rd_ptr_q];
  assign rd_sample = rd_bank[rd_ptr_q];
`else
  logic full_q, full_d;

  fft16_frame_bank u_bank (
    .clk      (clk),
    .we       (in_fire),
    .wr_frame (wr_frame),
    .rd_addr  (rd_addr),
    .rd_data  (rd_sample)
  );

  always_comb begin
    full_d = full_q;
    if (in_fire)         full_d = 1'b1;
    else if (frame_done) full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  assign in_ready  = ~full_q;
  assign out_valid = full_q;
`endif

  assign out_real  = out_valid ? rd_sample.re : '0;
  assign out_img   = out_valid ? rd_sample.im : '0;
  assign out_index = k_q;
  assign out_last  = out_valid && (k_q == 4'd15);

endmodule

// File: tb/tb_fft16_output_reorder.sv
// Randomized and directed bench for fft16_output_reorder against a queue-based frame model.
module tb_fft16_output_reorder;

`ifdef FFT16_REORDER_PINGPONG_EN
  localparam int unsigned NumBanks = 2;
`else
  localparam int unsigned NumBanks = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_real [0:15];
  logic [31:0] in_img  [0:15];
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_real;
  logic [31:0] out_img;
  logic [3:0]  out_index;
  logic        out_last;

  fft16_output_reorder #(
    .N_POINTS (16),
    .DATA_W   (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_img    (in_img),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_img   (out_img),
    .out_index (out_index),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: samples of accepted frames queued in natural frequency order {re, im}.
  logic [63:0] exp_q[$];
  int unsigned exp_k;
  int unsigned n_vec;
  int unsigned n_err;
  int unsigned offer_mode;  // 0: one frame then idle, 1: continuous frames, 2: random
  int unsigned next_base;
  bit          captured;

  int unsigned spec_order [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned bit_reverse(input int unsigned k);
    int unsigned r;
    r = 0;
    for (int b = 0; b < 4; b++) begin
      if (((k >> b) & 1) != 0) r = r + (1 << (3 - b));
    end
    return r;
  endfunction

  function automatic int unsigned model_frames();
    return (exp_q.size() + 15) / 16;
  endfunction

  task automatic load_pattern(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      in_real[i] = base + 32'(i);
      in_img[i]  = base + 32'h100 + 32'(i);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) begin
      in_real[i] = $urandom;
      in_img[i]  = $urandom;
    end
  endtask

  // Called at a falling edge: compare, advance one clock, update model, reach next falling edge.
  task automatic cycle();
    logic        exp_valid, exp_ready, in_fire, out_fire;
    logic [63:0] head;
    exp_valid = exp_q.size() != 0;
    exp_ready = model_frames() < NumBanks;
    head      = '0;
    if (exp_valid) head = exp_q[0];
    check_eq("in_ready",  32'(in_ready),  32'(exp_ready));
    check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
    check_eq("out_index", 32'(out_index), exp_k);
    check_eq("out_last",  32'(out_last),  32'(exp_valid && exp_k == 15));
    check_eq("out_real",  out_real,       head[63:32]);
    check_eq("out_img",   out_img,        head[31:0]);
    in_fire  = in_valid && exp_ready;
    out_fire = exp_valid && out_ready;
    @(posedge clk);
    if (out_fire) begin
      void'(exp_q.pop_front());
      exp_k = (exp_k + 1) % 16;
    end
    if (in_fire) begin
      for (int k = 0; k < 16; k++) begin
        exp_q.push_back({in_real[bit_reverse(k)], in_img[bit_reverse(k)]});
      end
    end
    captured = in_fire;
    @(negedge clk);
    if (captured) begin
      if (offer_mode == 0) begin
        in_valid = 1'b0;
      end else if (offer_mode == 1) begin
        load_pattern(next_base);
        next_base = next_base + 32'h200;
      end else begin
        load_random();
      end
    end
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < int'(n); i++) cycle();
  endtask

  task automatic wait_for_k(input int unsigned target, input int unsigned budget);
    int unsigned cnt;
    cnt = 0;
    while (!(exp_q.size() != 0 && exp_k == target) && cnt < budget) begin
      cycle();
      cnt++;
    end
    check_eq("wait_k", {27'd0, out_valid, out_index}, {27'd0, 1'b1, 4'(target)});
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    exp_k      = 0;
    offer_mode = 0;
    next_base  = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    load_pattern(32'h0);
    #1;
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_real",  out_real,       32'd0);
    check_eq("rst_out_index", 32'(out_index), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);

    // Bit-reversal order against the literal slot sequence.
    load_pattern(32'h0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    for (int i = 0; i < 16; i++) begin
      check_eq("order_re", out_real, spec_order[i]);
      check_eq("order_im", out_img, 32'h100 + spec_order[i]);
      cycle();
    end
    run(3);

    // Backpressure at k=3.
    load_pattern(32'h0);
    in_valid = 1'b1;
    wait_for_k(3, 40);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold", out_real, 32'd12);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    check_eq("bp_resume", out_real, 32'd2);
    run(16);

    // NaN / denormal pass through unchanged (slot 8 is read at k=1).
    load_random();
    in_real[8] = 32'h7FC0_0001;
    in_img[8]  = 32'h0000_0001;
    in_valid   = 1'b1;
    wait_for_k(1, 40);
    check_eq("nan_re",    out_real, 32'h7FC0_0001);
    check_eq("denorm_im", out_img,  32'h0000_0001);
    run(20);

    // Back-to-back frames: A (base 0) then B (base 0x200) offered continuously.
    offer_mode = 1;
    load_pattern(32'h0);
    next_base = 32'h200;
    in_valid  = 1'b1;
    wait_for_k(15, 40);
    cycle();
`ifdef FFT16_REORDER_PINGPONG_EN
    check_eq("b2b_x0", out_real, 32'h200);
`else
    check_eq("b2b_gap", 32'(out_valid), 32'd0);
    cycle();
    check_eq("b2b_x0", out_real, 32'h200);
`endif
    run(60);
    offer_mode = 0;
    in_valid   = 1'b0;
    run(40);

    // Asynchronous reset in the middle of a frame.
    load_random();
    in_valid = 1'b1;
    wait_for_k(7, 40);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_out_real",  out_real,       32'd0);
    check_eq("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("mid_rst_out_index", 32'(out_index), 32'd0);
    exp_q.delete();
    exp_k    = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_pattern(32'h0);
    in_valid = 1'b1;
    run(22);

    // Random traffic with random backpressure.
    offer_mode = 2;
    load_random();
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
